uart_spi_tx_router: RTL

Outbound byte router for the SPI-or-UART configurable top level. It accepts one byte per valid/ready handshake and latches a path select with it. It then serialises the byte either as a UART frame (8N1, LSB first) or as an SPI mode-0 master transfer (MSB first, chip-select framed). It is the transmit-side counterpart of the receive-path byte selector, which picks the incoming byte from either the UART or the SPI side.

---
 rtl/uart_spi_tx_router.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_spi_tx_router.sv
// -----------------------------------------------------------------------------
// uart_spi_tx_router
//   Outbound byte router. Takes one byte per valid/ready handshake together
//   with a path select. It then serialises the byte either as a UART 8N1 frame
//   (LSB first) or as an SPI mode-0 master transfer (MSB first, CS framed).
//
// Parameters
//   CLKS_PER_BIT    clk cycles per UART bit (>= 2)
//   SPI_HALF_PERIOD clk cycles per SCLK half-period (>= 1)
//
// Ports
//   clk, rst_n     system clock (rising edge), async active-low reset
//   sel            path select sampled at accept: 0 = UART, 1 = SPI
//   tx_data[7:0]   byte sampled at accept
//   tx_valid       byte offered
//   tx_ready       high iff idle; accept = tx_valid & tx_ready
//   busy           inverse of tx_ready
//   done           one-cycle pulse on transfer completion
//   uart_tx        UART line, idle high
//   spi_sclk       SPI clock, idle low
//   spi_mosi       SPI data out
//   spi_cs_n       SPI chip select, active low
// -----------------------------------------------------------------------------
module uart_spi_tx_router #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int SPI_HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       uart_tx,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HW = $clog2(SPI_HALF_PERIOD + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SPI_HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        U_START,
        U_DATA,
        U_STOP,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t        state;
    logic [7:0]    shreg;     // UART shifts right, SPI shifts left
    logic          path;      // latched sel: 1 = SPI transfer in flight
    logic [CW-1:0] bit_cnt;   // UART bit-time counter
    logic [HW-1:0] half_cnt;  // SCLK half-period counter
    logic [2:0]    bit_idx;   // UART data bit / SPI SCLK period index

    logic accept;
    logic phase_end;

    assign accept = tx_valid & tx_ready;

    // End of the current timing phase for whichever path is active.
    assign phase_end = path ? (half_cnt == HALF_LAST) : (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            path     <= 1'b0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            bit_idx  <= 3'd0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            uart_tx  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    half_cnt <= '0;
                    bit_idx  <= 3'd0;
                    if (accept) begin
                        shreg    <= tx_data;
                        path     <= sel;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (sel) begin
                            state    <= S_SETUP;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= tx_data[7];
                        end else begin
                            state   <= U_START;
                            uart_tx <= 1'b0;
                        end
                    end
                end

                U_START: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        state   <= U_DATA;
                        uart_tx <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                U_DATA: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= U_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                U_STOP: begin
                    if (phase_end) begin
                        bit_cnt  <= '0;
                        state    <= IDLE;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_SETUP: begin
                    // MSB already on MOSI; first rise ends the setup phase.
                    if (phase_end) begin
                        half_cnt <= '0;
                        state    <= S_SHIFT;
                        spi_sclk <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        if (spi_sclk) begin
                            // Falling edge: advance MOSI except after the
                            // last period, where data[0] is held.
                            spi_sclk <= 1'b0;
                            if (bit_idx != 3'd7) begin
                                spi_mosi <= shreg[6];
                                shreg    <= {shreg[6:0], 1'b0};
                            end
                        end else if (bit_idx == 3'd7) begin
                            // Low half of the 8th period is complete.
                            bit_idx <= 3'd0;
                            state   <= S_HOLD;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            spi_sclk <= 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (phase_end) begin
                        half_cnt <= '0;
                        state    <= IDLE;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    uart_tx  <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b0;
                    spi_cs_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
